port_out_hs: RTL and testbench

PORT_OUT_HS -- requirements
Module: port_out_hs

---
 rtl/port_out_hs.sv | 135 +++++++++++++
 tb/tb_port_out_hs.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/port_out_hs.sv
// Peripheral output port with one CPU-visible output register, a 4-bit control register
// and a cb1/cb2 handshake FSM. Define PORT_OUT_HS_CB1_SYNC_EN to put a 2-flop synchronizer on cb1.
module port_out_hs (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] datain,
   input  logic       cs1,
   input  logic       cs2,
   input  logic       cs3,
   input  logic       rw,
   input  logic       rs,
   output logic [7:0] dataout,
   output logic [7:0] pb,
   input  logic       cb1,
   output logic       cb2,
   output logic       irq_n
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE} state_t;

   state_t     r_state;
   logic [7:0] r_orb;
   logic [3:0] r_crb;
   logic       r_flag;
   logic       r_cb1_q;
   logic       r_cb2;

   logic       w_sel;
   logic       w_orb_wr;
   logic       w_crb_wr;
   logic       w_cb1;
   logic       w_edge;
   logic [1:0] w_mode_nxt;
   logic       w_mode_chg;

   assign w_sel    = cs1 & cs2 & ~cs3;
   assign w_orb_wr = w_sel & ~rw & ~rs;
   assign w_crb_wr = w_sel & ~rw & rs;

`ifdef PORT_OUT_HS_CB1_SYNC_EN
   logic r_cb1_s1;
   logic r_cb1_s2;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cb1_s1 <= 1'b0;
         r_cb1_s2 <= 1'b0;
      end else begin
         r_cb1_s1 <= cb1;
         r_cb1_s2 <= r_cb1_s1;
      end
   end

   assign w_cb1 = r_cb1_s2;
`else
   assign w_cb1 = cb1;
`endif

   // Active edge: input moved and now sits at the level selected by CRB[1].
   assign w_edge     = (w_cb1 != r_cb1_q) && (w_cb1 == r_crb[1]);
   assign w_mode_nxt = w_crb_wr ? datain[3:2] : r_crb[3:2];
   assign w_mode_chg = w_crb_wr && (datain[3:2] != r_crb[3:2]);

   // NOTE: every register below uses non-blocking assignment so all of them sample
   // the same pre-edge values; blocking here would make results depend on block order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_orb   <= 8'h00;
         r_crb   <= 4'h0;
         r_flag  <= 1'b0;
         r_cb1_q <= 1'b0;
      end else begin
         r_cb1_q <= w_cb1;
         if (w_orb_wr) r_orb <= datain;
         if (w_crb_wr) r_crb <= datain[3:0];
         // Edge set has priority over the clear caused by an ORB write.
         if (w_edge)        r_flag <= 1'b1;
         else if (w_orb_wr) r_flag <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cb2   <= 1'b1;
      end else if (w_mode_chg || w_mode_nxt[1]) begin
         // Mode change aborts any handshake; manual modes drive cb2 straight from CRB[2].
         r_state <= S_IDLE;
         r_cb2   <= w_mode_nxt[1] ? w_mode_nxt[0] : 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_orb_wr) begin
                  r_state <= (w_mode_nxt == 2'b00) ? S_WAIT : S_PULSE;
                  r_cb2   <= 1'b0;
               end else begin
                  r_cb2   <= 1'b1;
               end
            end
            S_WAIT: begin
               if (w_orb_wr) begin
                  r_cb2   <= 1'b0;
               end else if (w_edge) begin
                  r_state <= S_IDLE;
                  r_cb2   <= 1'b1;
               end
            end
            S_PULSE: begin
               if (w_orb_wr) begin
                  r_cb2   <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_cb2   <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cb2   <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      dataout = 8'h00;
      if (w_sel && rw) begin
         dataout = rs ? {r_flag, 3'b000, r_crb} : r_orb;
      end
   end

   assign pb    = r_orb;
   assign cb2   = r_cb2;
   assign irq_n = ~(r_flag & r_crb[0]);

endmodule

// File: tb/tb_port_out_hs.sv
// Self-checking bench for port_out_hs: directed vector table, reset corner cases,
// then randomized traffic against a behavioural model of the port.
module tb_port_out_hs;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] datain;
   logic       cs1, cs2, cs3, rw, rs, cb1;
   logic [7:0] dataout, pb;
   logic       cb2, irq_n;

   int n_checks = 0;
   int n_errors = 0;

   port_out_hs dut (
      .clk(clk), .reset(reset), .datain(datain),
      .cs1(cs1), .cs2(cs2), .cs3(cs3), .rw(rw), .rs(rs),
      .dataout(dataout), .pb(pb), .cb1(cb1), .cb2(cb2), .irq_n(irq_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] cs;      // {cs1,cs2,cs3}
      logic       rw;
      logic       rs;
      logic [7:0] din;
      logic       cb1;
      logic [7:0] exp_do;  // dataout before the edge
      logic [7:0] exp_pb;  // after the edge
      logic       exp_cb2;
      logic       exp_irq_n;
   } vec_t;

   vec_t vecs[$];

   // Behavioural model of the port.
   logic [7:0] m_orb;
   logic [3:0] m_crb;
   logic       m_flag, m_prev, m_pending, m_pulse;
   logic [1:0] m_dly;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [2:0] cs, input logic r, input logic s,
                        input logic [7:0] d, input logic c);
      {cs1, cs2, cs3} = cs;
      rw = r; rs = s; datain = d; cb1 = c;
   endtask

   task automatic model_reset();
      m_orb = 8'h00; m_crb = 4'h0; m_flag = 1'b0; m_prev = 1'b0;
      m_pending = 1'b0; m_pulse = 1'b0; m_dly = 2'b00;
   endtask

   function automatic logic [7:0] model_dout();
      if (cs1 && cs2 && !cs3 && rw) return rs ? {m_flag, 3'b000, m_crb} : m_orb;
      return 8'h00;
   endfunction

   function automatic logic model_cb2();
      if (m_crb[3]) return m_crb[2];
      return !(m_pending || m_pulse);
   endfunction

   task automatic model_step();
      logic sel, wo, wc, eff, active;
      sel = cs1 && cs2 && !cs3;
      wo  = sel && !rw && !rs;
      wc  = sel && !rw && rs;
`ifdef PORT_OUT_HS_CB1_SYNC_EN
      eff   = m_dly[1];
      m_dly = {m_dly[0], cb1};
`else
      eff = cb1;
`endif
      active = (eff != m_prev) && (eff == m_crb[1]);
      if (active) m_flag = 1'b1;
      else if (wo) m_flag = 1'b0;
      if (wc && datain[3:2] != m_crb[3:2]) begin
         m_pending = 1'b0; m_pulse = 1'b0;
      end else if (m_crb[3]) begin
         m_pending = 1'b0; m_pulse = 1'b0;
      end else if (m_crb[2:1] == 2'b00 || m_crb[3:2] == 2'b00) begin
         // Handshake: write arms it, acknowledge edge releases it, write wins.
         m_pending = wo ? 1'b1 : (active ? 1'b0 : m_pending);
         m_pulse   = 1'b0;
      end
      if (!m_crb[3] && m_crb[2] && !(wc && datain[3:2] != m_crb[3:2])) begin
         // Pulse: low for the cycle after each write.
         m_pulse   = wo;
         m_pending = 1'b0;
      end
      if (wo) m_orb = datain;
      if (wc) m_crb = datain[3:0];
      m_prev = eff;
   endtask

   task automatic cyc(input logic [2:0] cs, input logic r, input logic s,
                      input logic [7:0] d, input logic c);
      drive(cs, r, s, d, c);
      @(posedge clk);
      #1;
      @(negedge clk);
   endtask

   initial begin
      // Directed table, starting from reset with cb1 low.
      vecs.push_back('{3'b110, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b1});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b1, 8'h02, 8'hA5, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b1, 8'h82, 8'hA5, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b1, 1'b0, 8'h00, 1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'h11, 1'b1, 8'h00, 8'h11, 1'b0, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b1, 8'h05, 1'b1, 8'h00, 8'h11, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'h3C, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b1});
      vecs.push_back('{3'b110, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b0, 8'h05, 8'h3C, 1'b1, 1'b0});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b0, 8'h85, 8'h3C, 1'b1, 1'b0});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'h77, 1'b0, 8'h00, 8'h77, 1'b0, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'h78, 1'b0, 8'h00, 8'h78, 1'b0, 1'b1});
      vecs.push_back('{3'b110, 1'b1, 1'b0, 8'h00, 1'b0, 8'h78, 8'h78, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 8'h78, 1'b1, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'hC3, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b1, 8'h83, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b111, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b111, 1'b0, 1'b1, 8'h0C, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b111, 1'b1, 1'b1, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b1, 8'h83, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b110, 1'b0, 1'b1, 8'hFF, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0});
      vecs.push_back('{3'b110, 1'b1, 1'b1, 8'h00, 1'b1, 8'h8F, 8'hC3, 1'b1, 1'b0});
      vecs.push_back('{3'b110, 1'b0, 1'b1, 8'h0B, 1'b1, 8'h00, 8'hC3, 1'b0, 1'b0});
      vecs.push_back('{3'b110, 1'b0, 1'b0, 8'h99, 1'b1, 8'h00, 8'h99, 1'b0, 1'b1});

      // Reset values, sampled while reset is held.
      reset = 1'b1;
      drive(3'b110, 1'b1, 1'b0, 8'h00, 1'b0);
      #1 reset = 1'b0;
      #2;
      check("rst_do_orb", dataout, 8'h00);
      check("rst_pb", pb, 8'h00);
      check("rst_cb2", {7'd0, cb2}, 8'h01);
      check("rst_irq_n", {7'd0, irq_n}, 8'h01);
      rs = 1'b1;
      #1 check("rst_do_crb", dataout, 8'h00);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].cs, vecs[i].rw, vecs[i].rs, vecs[i].din, vecs[i].cb1);
         #1 check($sformatf("v%0d_dataout", i), dataout, vecs[i].exp_do);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_pb", i), pb, vecs[i].exp_pb);
         check($sformatf("v%0d_cb2", i), {7'd0, cb2}, {7'd0, vecs[i].exp_cb2});
         check($sformatf("v%0d_irq_n", i), {7'd0, irq_n}, {7'd0, vecs[i].exp_irq_n});
         @(negedge clk);
      end

      // Reset asserted mid-handshake with the flag set.
      cyc(3'b110, 1'b0, 1'b1, 8'h03, 1'b0);
      cyc(3'b110, 1'b0, 1'b0, 8'h42, 1'b0);
      cyc(3'b110, 1'b0, 1'b0, 8'h24, 1'b1);
      check("wait_cb2", {7'd0, cb2}, 8'h00);
      check("wait_irq_n", {7'd0, irq_n}, 8'h00);
      drive(3'b110, 1'b1, 1'b1, 8'h00, 1'b1);
      #2 reset = 1'b0;
      #1;
      check("arst_cb2", {7'd0, cb2}, 8'h01);
      check("arst_irq_n", {7'd0, irq_n}, 8'h01);
      check("arst_pb", pb, 8'h00);
      check("arst_crb_flag", dataout, 8'h00);
      @(negedge clk);
      drive(3'b110, 1'b1, 1'b0, 8'h00, 1'b0);
      reset = 1'b1;
      model_reset();

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         logic [2:0] cs;
         cs = 3'b110;
         if ($urandom_range(0, 7) == 0) cs[2] = 1'b1;
         if ($urandom_range(0, 15) == 0) cs[$urandom_range(0, 1) + 1] = 1'b0;
         drive(cs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
               8'($urandom), ($urandom_range(0, 3) == 0) ? ~cb1 : cb1);
         #1 check("rnd_dataout", dataout, model_dout());
         @(posedge clk);
         model_step();
         #1;
         check("rnd_pb", pb, m_orb);
         check("rnd_cb2", {7'd0, cb2}, {7'd0, model_cb2()});
         check("rnd_irq_n", {7'd0, irq_n}, {7'd0, ~(m_flag & m_crb[0])});
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
